// File: rtl/equation_scheduler.sv
// rtl/equation_scheduler.sv - sequences the equation checkers with per-attempt timeout and wrong-answer penalty
module equation_scheduler #(
    parameter int NUM_EQ      = 3,
    parameter int TIMEOUT_SEC = 20,
    parameter int MAX_WRONG   = 2,
    parameter int TICK_DIV    = 50000000
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Begin,
    input  logic [NUM_EQ-1:0] eqDone,
    input  logic [NUM_EQ-1:0] eqCorrect,
    input  logic              penaltyAck,
    output logic [NUM_EQ-1:0] eqStart,
    output logic [1:0]        eqIndex,
    output logic [6:0]        secondsLeft,
    output logic [3:0]        wrongCount,
    output logic              penalty,
    output logic              allDone,
    output logic              busy
);

    localparam int              PS_W     = $clog2(TICK_DIV);
    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(TICK_DIV - 1);
    localparam logic [6:0]      SEC_LOAD = 7'(TIMEOUT_SEC);
    localparam logic [3:0]      WRONG_LIM = 4'(MAX_WRONG);
    localparam logic [1:0]      LAST_IDX = 2'(NUM_EQ - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        PENALTY,
        FINISH
    } state_t;

    state_t            state;
    logic [PS_W-1:0]   prescaler;
    logic [NUM_EQ-1:0] sel;
    logic              done_cur;
    logic              correct_cur;
    logic              tick;
    logic [3:0]        wrong_next;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_EQ; i++) begin
            sel[i] = (eqIndex == 2'(i));
        end
        done_cur    = |(eqDone & sel);
        correct_cur = |(eqDone & eqCorrect & sel);
        tick        = (prescaler == PS_LAST);
        wrong_next  = (wrongCount == 4'd15) ? 4'd15 : wrongCount + 4'd1;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            prescaler   <= '0;
            eqStart     <= '0;
            eqIndex     <= 2'd0;
            secondsLeft <= 7'd0;
            wrongCount  <= 4'd0;
            penalty     <= 1'b0;
            allDone     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            penalty <= 1'b0;
            allDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (Begin) begin
                        state      <= ISSUE;
                        eqIndex    <= 2'd0;
                        wrongCount <= 4'd0;
                        busy       <= 1'b1;
                    end
                end
                ISSUE: begin
                    state       <= WAIT;
                    secondsLeft <= SEC_LOAD;
                    prescaler   <= '0;
                    eqStart     <= sel;
                end
                WAIT: begin
                    // An answer on the same edge as the final tick wins; the tick is dropped.
                    if (correct_cur) begin
                        eqStart <= '0;
                        if (eqIndex == LAST_IDX) begin
                            state   <= FINISH;
                            allDone <= 1'b1;
                        end else begin
                            eqIndex <= eqIndex + 2'd1;
                            state   <= ISSUE;
                        end
                    end else if (done_cur || (tick && secondsLeft == 7'd1)) begin
                        wrongCount <= wrong_next;
                        if (wrong_next >= WRONG_LIM) begin
                            state   <= PENALTY;
                            penalty <= 1'b1;
                            eqStart <= '0;
                        end else begin
                            secondsLeft <= SEC_LOAD;
                            prescaler   <= '0;
                        end
                    end else if (tick) begin
                        prescaler   <= '0;
                        secondsLeft <= secondsLeft - 7'd1;
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end
                PENALTY: begin
                    if (penaltyAck) begin
                        wrongCount <= 4'd0;
                        state      <= ISSUE;
                    end
                end
                FINISH: begin
                    state       <= IDLE;
                    eqIndex     <= 2'd0;
                    secondsLeft <= 7'd0;
                    busy        <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_equation_scheduler.sv
// tb/tb_equation_scheduler.sv - directed bench with a cycle-level reference model for equation_scheduler
module tb_equation_scheduler;

    localparam int NUM     = 3;
    localparam int TIMEOUT = 3;
    localparam int MAXW    = 2;
    localparam int TICK    = 4;

    localparam int MI = 0, MG = 1, MW = 2, MP = 3, MF = 4;

    logic           Clock = 1'b0;
    logic           Reset = 1'b1;
    logic           Begin = 1'b0;
    logic [NUM-1:0] eqDone = '0;
    logic [NUM-1:0] eqCorrect = '0;
    logic           penaltyAck = 1'b0;
    logic [NUM-1:0] eqStart;
    logic [1:0]     eqIndex;
    logic [6:0]     secondsLeft;
    logic [3:0]     wrongCount;
    logic           penalty;
    logic           allDone;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;

    // Model: attempt progress is tracked as elapsed cycles; displayed seconds derive from it.
    int m_mode = MI, m_idx = 0, m_wc = 0, m_cyc = 0, m_hold = 0, m_pen = 0, m_fin = 0;
    int shown;
    bit ans, ok;

    equation_scheduler #(
        .NUM_EQ(NUM), .TIMEOUT_SEC(TIMEOUT), .MAX_WRONG(MAXW), .TICK_DIV(TICK)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Begin(Begin), .eqDone(eqDone), .eqCorrect(eqCorrect),
        .penaltyAck(penaltyAck), .eqStart(eqStart), .eqIndex(eqIndex), .secondsLeft(secondsLeft),
        .wrongCount(wrongCount), .penalty(penalty), .allDone(allDone), .busy(busy)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            m_mode = MI; m_idx = 0; m_wc = 0; m_cyc = 0; m_hold = 0; m_pen = 0; m_fin = 0;
        end else begin
            shown = (m_mode == MW) ? TIMEOUT - m_cyc / TICK : m_hold;
            m_pen = 0;
            m_fin = 0;
            case (m_mode)
                MI: if (Begin) begin m_mode = MG; m_idx = 0; m_wc = 0; end
                MG: begin m_mode = MW; m_cyc = 0; end
                MW: begin
                    ans = eqDone[m_idx];
                    ok  = eqCorrect[m_idx];
                    if (ans && ok) begin
                        m_hold = shown;
                        if (m_idx == NUM - 1) begin m_mode = MF; m_fin = 1; end
                        else begin m_idx++; m_mode = MG; end
                    end else if (ans || m_cyc + 1 == TIMEOUT * TICK) begin
                        m_wc = (m_wc < 15) ? m_wc + 1 : 15;
                        if (m_wc >= MAXW) begin m_hold = shown; m_mode = MP; m_pen = 1; end
                        else m_cyc = 0;
                    end else begin
                        m_cyc++;
                    end
                end
                MP: if (penaltyAck) begin m_wc = 0; m_mode = MG; end
                MF: begin m_mode = MI; m_idx = 0; m_hold = 0; end
                default: m_mode = MI;
            endcase
        end
    end

    always @(negedge Clock) begin
        check("busy", busy, m_mode != MI);
        check("eqStart", eqStart, (m_mode == MW) ? (1 << m_idx) : 0);
        check("eqIndex", eqIndex, m_idx);
        check("secondsLeft", secondsLeft, (m_mode == MW) ? TIMEOUT - m_cyc / TICK : m_hold);
        check("wrongCount", wrongCount, m_wc);
        check("penalty", penalty, m_pen);
        check("allDone", allDone, m_fin);
        if (allDone) done_pulses++;
    end

    task automatic start_phase();
        Begin = 1'b1;
        @(negedge Clock);
        Begin = 1'b0;
        check("begin_busy", busy, 1);
        check("begin_gap", eqStart, 0);
    endtask

    task automatic wait_start(input int idx);
        int n = 0;
        while (eqStart !== NUM'(1 << idx) && n < 30) begin
            @(negedge Clock);
            n++;
        end
        check("wait_start", eqStart, 1 << idx);
    endtask

    task automatic answer(input int idx, input bit correct);
        eqDone[idx]    = 1'b1;
        eqCorrect[idx] = correct;
        @(negedge Clock);
        eqDone    = '0;
        eqCorrect = '0;
    endtask

    initial begin
        @(negedge Clock);
        check("rst_busy", busy, 0);
        check("rst_eqStart", eqStart, 0);
        check("rst_seconds", secondsLeft, 0);
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);

        // Happy path
        start_phase();
        for (int i = 0; i < NUM; i++) begin
            wait_start(i);
            answer(i, 1'b1);
            check("hp_gap", eqStart, 0);
        end
        check("hp_alldone", allDone, 1);
        @(negedge Clock);
        check("hp_busy", busy, 0);
        check("hp_wrong", wrongCount, 0);
        check("hp_pulses", done_pulses, 1);

        // Stray eqDone[2] and Begin while busy, then collision on final tick
        start_phase();
        wait_start(0);
        check("st_sec0", secondsLeft, 3);
        Begin = 1'b1;
        answer(2, 1'b1);
        Begin = 1'b0;
        check("st_idx", eqIndex, 0);
        check("st_start", eqStart, 3'b001);
        check("st_wrong", wrongCount, 0);
        repeat (10) @(negedge Clock);
        check("col_sec", secondsLeft, 1);
        answer(0, 1'b1);
        check("col_idx", eqIndex, 1);
        check("col_wrong", wrongCount, 0);

        // Penalty on idx 1
        wait_start(1);
        repeat (5) @(negedge Clock);
        check("pn_sec2", secondsLeft, 2);
        answer(1, 1'b0);
        check("pn_wc1", wrongCount, 1);
        check("pn_reload", secondsLeft, 3);
        answer(1, 1'b0);
        check("pn_pulse", penalty, 1);
        check("pn_start0", eqStart, 0);
        check("pn_wc2", wrongCount, 2);
        @(negedge Clock);
        check("pn_pulse_end", penalty, 0);
        repeat (2) @(negedge Clock);
        penaltyAck = 1'b1;
        @(negedge Clock);
        penaltyAck = 1'b0;
        check("pn_wc0", wrongCount, 0);
        @(negedge Clock);
        check("pn_idx", eqIndex, 1);
        check("pn_start", eqStart, 3'b010);
        answer(1, 1'b1);
        wait_start(2);
        answer(2, 1'b1);
        @(negedge Clock);

        // Timeout with no answer
        start_phase();
        wait_start(0);
        check("to_s3", secondsLeft, 3);
        repeat (4) @(negedge Clock);
        check("to_s2", secondsLeft, 2);
        repeat (4) @(negedge Clock);
        check("to_s1", secondsLeft, 1);
        repeat (4) @(negedge Clock);
        check("to_wc", wrongCount, 1);
        check("to_reload", secondsLeft, 3);

        // Asynchronous reset mid-WAIT
        repeat (2) @(negedge Clock);
        #2 Reset = 1'b1;
        #1;
        check("ar_busy", busy, 0);
        check("ar_start", eqStart, 0);
        check("ar_idx", eqIndex, 0);
        check("ar_sec", secondsLeft, 0);
        check("ar_wc", wrongCount, 0);
        check("ar_pen", penalty, 0);
        check("ar_done", allDone, 0);
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        start_phase();
        wait_start(0);
        check("ar_restart_idx", eqIndex, 0);
        check("ar_restart_wc", wrongCount, 0);
        repeat (2) @(negedge Clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
